// File: rtl/top6_collector.sv
// Collects the top-6 selector's serial result stream into a rank-addressed bank.
// Tracks completion, running sum, sortedness and the first error cause; registered readout.
module top6_collector #(
   parameter int NUM_RANK = 6,
   parameter int VALUE_W  = 8,
   parameter int INDEX_W  = 5,
   parameter int RANK_W   = 3,
   parameter int SUM_W    = 11
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [VALUE_W+INDEX_W+RANK_W-1:0] DataIn,
   input  logic                         DataValid,
   input  logic                         Clear,
   input  logic [RANK_W-1:0]            RdAddr,
   output logic [VALUE_W+INDEX_W-1:0]   RdData,
   output logic                         Done,
   output logic [SUM_W-1:0]             ValueSum,
   output logic                         Sorted,
   output logic                         Error,
   output logic [1:0]                   ErrCode
);
   localparam int ENTRY_W = VALUE_W + INDEX_W;
   localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(NUM_RANK - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   localparam logic [1:0] E_NONE  = 2'b00;
   localparam logic [1:0] E_RANGE = 2'b01;
   localparam logic [1:0] E_DUP   = 2'b10;

   logic [1:0]                        state;
   logic [NUM_RANK-1:0]               mask;
   logic [NUM_RANK-1:0]               mask_nxt;
   logic [NUM_RANK-1:0][ENTRY_W-1:0]  entry;
   logic [NUM_RANK-1:0]               wr_sel;
   logic [ENTRY_W-1:0]                rd_mux;
   logic [RANK_W-1:0]                 rank;
   logic [VALUE_W-1:0]                value;
   logic                              accept, in_range, dup, store;

   assign rank     = DataIn[RANK_W-1:0];
   assign value    = DataIn[RANK_W+INDEX_W +: VALUE_W];
   assign accept   = DataValid && !Clear && (state != S_DONE);
   assign in_range = (rank <= LAST_RANK);
   assign wr_sel   = in_range ? (NUM_RANK'(1) << rank) : '0;
   assign dup      = |(mask & wr_sel);
   assign store    = accept && in_range && !dup;
   assign mask_nxt = mask | wr_sel;
   assign Done     = (state == S_DONE);

   // Out-of-range read addresses fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_RANK; i++)
         if (RdAddr == RANK_W'(i)) rd_mux = entry[i];
   end

   // Ties count as sorted; only meaningful once every rank is filled.
   always_comb begin
      Sorted = 1'b1;
      for (int i = 0; i < NUM_RANK - 1; i++)
         if (entry[i][ENTRY_W-1 -: VALUE_W] < entry[i+1][ENTRY_W-1 -: VALUE_W]) Sorted = 1'b0;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= S_IDLE;
         mask     <= '0;
         entry    <= '0;
         RdData   <= '0;
         ValueSum <= '0;
         Error    <= 1'b0;
         ErrCode  <= E_NONE;
      end else begin
         // Read samples the bank before this edge's write lands.
         RdData <= rd_mux;
         if (Clear) begin
            state    <= S_IDLE;
            mask     <= '0;
            entry    <= '0;
            ValueSum <= '0;
            Error    <= 1'b0;
            ErrCode  <= E_NONE;
         end else if (accept) begin
            if (!in_range) begin
               Error <= 1'b1;
               if (ErrCode == E_NONE) ErrCode <= E_RANGE;
            end else if (dup) begin
               Error <= 1'b1;
               if (ErrCode == E_NONE) ErrCode <= E_DUP;
            end else begin
               mask     <= mask_nxt;
               ValueSum <= ValueSum + SUM_W'(value);
               for (int i = 0; i < NUM_RANK; i++)
                  if (wr_sel[i]) entry[i] <= DataIn[RANK_W +: ENTRY_W];
               state <= (&mask_nxt) ? S_DONE : S_COLLECT;
            end
         end
      end
   end
endmodule

// File: tb/tb_top6_collector.sv
// Randomized and directed bench for top6_collector against an array-based reference model.
module tb_top6_collector;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] DataIn = '0;
   logic        DataValid = 1'b0;
   logic        Clear = 1'b0;
   logic [2:0]  RdAddr = '0;
   logic [12:0] RdData;
   logic        Done;
   logic [10:0] ValueSum;
   logic        Sorted;
   logic        Error;
   logic [1:0]  ErrCode;

   top6_collector dut (
      .Clk(Clk), .Reset(Reset), .DataIn(DataIn), .DataValid(DataValid), .Clear(Clear),
      .RdAddr(RdAddr), .RdData(RdData), .Done(Done), .ValueSum(ValueSum),
      .Sorted(Sorted), .Error(Error), .ErrCode(ErrCode)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: what has been filed at each rank, plus error bookkeeping.
   int m_val [6];
   int m_idx [6];
   bit m_fill[6];
   int m_sum;
   bit m_err;
   int m_code;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic bit m_done();
      int n = 0;
      for (int i = 0; i < 6; i++) n += m_fill[i];
      return n == 6;
   endfunction

   function automatic bit m_sorted();
      for (int i = 0; i < 5; i++) if (m_val[i] < m_val[i+1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 6; i++) begin m_val[i] = 0; m_idx[i] = 0; m_fill[i] = 0; end
      m_sum = 0; m_err = 0; m_code = 0;
   endtask

   // One clock: drive, advance model, then check all outputs after the edge.
   task automatic cyc(input bit v, input bit c, input int rank, input int val, input int idx, input int ra);
      int exp_rd;
      DataValid = v;
      Clear     = c;
      DataIn    = {val[7:0], idx[4:0], rank[2:0]};
      RdAddr    = ra[2:0];
      exp_rd    = (ra < 6) ? (m_val[ra] * 32 + m_idx[ra]) : 0;
      if (c) m_clear();
      else if (v && !m_done()) begin
         if (rank >= 6) begin
            m_err = 1; if (m_code == 0) m_code = 1;
         end else if (m_fill[rank]) begin
            m_err = 1; if (m_code == 0) m_code = 2;
         end else begin
            m_fill[rank] = 1; m_val[rank] = val; m_idx[rank] = idx; m_sum += val;
         end
      end
      @(posedge Clk);
      #1;
      DataValid = 1'b0;
      Clear     = 1'b0;
      chk("rddata", RdData, exp_rd);
      chk("done", Done, m_done());
      chk("sum", ValueSum, m_sum);
      chk("error", Error, m_err);
      chk("errcode", ErrCode, m_code);
      if (m_done()) chk("sorted", Sorted, m_sorted());
   endtask

   task automatic idle(input int n, input int ra);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, ra);
   endtask

   int tv[6] = '{245, 245, 243, 217, 204, 202};
   int ti[6] = '{0, 2, 15, 7, 3, 5};
   int ord[6] = '{5, 3, 0, 1, 4, 2};
   int uv[6] = '{100, 200, 50, 40, 30, 20};

   initial begin
      m_clear();
      #3;
      chk("rst_rd", RdData, 0);
      chk("rst_done", Done, 0);
      chk("rst_sum", ValueSum, 0);
      chk("rst_err", Error, 0);
      chk("rst_code", ErrCode, 0);
      @(negedge Clk);
      Reset = 1'b0;

      // Back-to-back fill in rank order.
      for (int r = 0; r < 6; r++) cyc(1, 0, r, tv[r], ti[r], 0);
      chk("t1_done", Done, 1);
      chk("t1_sum", ValueSum, 1356);
      chk("t1_sorted", Sorted, 1);
      cyc(0, 0, 0, 0, 0, 2);
      chk("t1_rd2", RdData, 243 * 32 + 15);
      cyc(1, 0, 3, 1, 1, 0);   // ignored in DONE, no error
      chk("t1_ign_err", Error, 0);

      // Scattered order with gaps; read every rank back.
      cyc(0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         cyc(1, 0, ord[k], tv[ord[k]], ti[ord[k]], 0);
         if (k < 5) chk("t2_not_done", Done, 0);
         idle(2, 0);
      end
      chk("t2_sum", ValueSum, 1356);
      for (int r = 0; r < 8; r++) cyc(0, 0, 0, 0, 0, r);

      // Duplicate rank 1.
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, tv[0], ti[0], 1);
      cyc(1, 0, 1, 245, ti[1], 1);
      cyc(1, 0, 1, 10, 9, 1);
      chk("t3_code", ErrCode, 2);
      for (int r = 2; r < 6; r++) cyc(1, 0, r, tv[r], ti[r], 1);
      chk("t3_done", Done, 1);
      chk("t3_sum", ValueSum, 1356);
      cyc(0, 0, 0, 0, 0, 1);
      chk("t3_rd1", RdData, 245 * 32 + ti[1]);

      // Range error first, then a duplicate: first cause sticks.
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 6, 99, 1, 0);
      cyc(1, 0, 3, tv[3], ti[3], 0);
      cyc(1, 0, 3, 50, 4, 3);
      chk("t4_code", ErrCode, 1);
      chk("t4_sum", ValueSum, 217);

      // Unsorted values.
      cyc(0, 1, 0, 0, 0, 0);
      for (int r = 0; r < 6; r++) cyc(1, 0, r, uv[r], r, 0);
      chk("t5_sorted", Sorted, 0);
      chk("t5_sum", ValueSum, 440);

      // Clear wins over simultaneous data mid-collection.
      cyc(0, 1, 0, 0, 0, 0);
      for (int r = 0; r < 3; r++) cyc(1, 0, r, tv[r], ti[r], 0);
      cyc(1, 1, 3, tv[3], ti[3], 0);
      chk("t6_sum", ValueSum, 0);
      cyc(0, 0, 0, 0, 0, 3);
      chk("t6_rd3", RdData, 0);

      // Async reset between edges.
      for (int r = 0; r < 4; r++) cyc(1, 0, r, tv[r], ti[r], r);
      cyc(1, 0, 6, 1, 1, 1);
      #2;
      Reset = 1'b1;
      #1;
      chk("ar_rd", RdData, 0);
      chk("ar_sum", ValueSum, 0);
      chk("ar_err", Error, 0);
      chk("ar_done", Done, 0);
      m_clear();
      #1;
      Reset = 1'b0;

      // Random traffic, mostly legal ranks, occasional clears.
      for (int n = 0; n < 600; n++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
             ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5),
             $urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 7));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
